// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Constants and types shared by the UART receiver and transmitter so that
//   both ends of the link stay matched.
//     DEFAULT_BAUD_DIV  : CLKIN cycles per bit (12 MHz / 103 ~= 115200 baud)
//     DEFAULT_DATA_BITS : payload bits per frame, LSB first
//     rx_state_t        : receiver FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV  = 103;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//   Mod-DIV bit timer with synchronous clear. tick is high while the count
//   equals the selected compare value: HALF-1 (mid-start search) when
//   sel_half is set, otherwise DIV-1 (one full bit period).
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     clear    in   synchronous clear, count returns to 0 on the next edge
//     sel_half in   1: compare at HALF-1, 0: compare at DIV-1
//     tick     out  terminal count reached (combinational from the count)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int DIV  = 103,
    parameter int HALF = 51
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sel_half,
    output logic tick
);

    localparam int           W         = $clog2(DIV);
    localparam logic [W-1:0] LAST      = W'(DIV - 1);
    localparam logic [W-1:0] HALF_LAST = W'(HALF - 1);

    logic [W-1:0] count;

    assign tick = (count == (sel_half ? HALF_LAST : LAST));

    // NOTE: state is written with <= so every flop samples the pre-edge values;
    // blocking assignments here would make the result depend on block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            // Wrapping at DIV-1 keeps the count inside 0..DIV-1 even if clear
            // is never asserted.
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule : uart_bit_timer

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver. RX is synchronized with two flops, the start edge
//   is confirmed at mid-start, and every following bit is sampled one bit
//   period later, i.e. at mid-bit. A good stop bit updates DATA and pulses
//   VALID; a low stop bit pulses FRAME_ERR and waits for the line to return
//   high before looking for another start bit.
//   Ports:
//     CLKIN      in   system clock (12 MHz)
//     RESETN     in   asynchronous active-low reset
//     RX         in   serial input, idle high, asynchronous to CLKIN
//     DATA       out  last good byte, held until the next good frame
//     VALID      out  one-cycle pulse, DATA is new on this cycle
//     FRAME_ERR  out  one-cycle pulse, stop bit sampled low
//     BUSY       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int HALF_DIV  = (BAUD_DIV - 1) / 2,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 CLKIN,
    input  logic                 RESETN,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int               IDX_W    = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [1:0]           sync;
    logic                 rxs;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick;
    logic                 timer_clear;
    logic                 sel_half;

    // Synchronizer flops reset to the idle level so releasing reset can
    // never look like a falling start edge.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], RX};
        end
    end

    assign rxs = sync[1];

    // The timer is held at zero while idle or waiting out a break, so it
    // reads 0 on the first START cycle. Every tick also restarts it, which
    // gives each state change its "timer=0" without extra control.
    assign timer_clear = (state == RX_IDLE) || (state == RX_BREAK) || tick;
    assign sel_half    = (state == RX_START);

    uart_bit_timer #(
        .DIV  (BAUD_DIV),
        .HALF (HALF_DIV)
    ) u_bit_timer (
        .clk      (CLKIN),
        .rst_n    (RESETN),
        .clear    (timer_clear),
        .sel_half (sel_half),
        .tick     (tick)
    );

    // NOTE: the shift register and DATA are ordinary flops and are cleared
    // with everything else, so a reset mid-frame leaves no stale payload.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state     <= RX_IDLE;
            bit_idx   <= '0;
            shreg     <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;

            case (state)
                RX_IDLE: begin
                    if (!rxs) begin
                        state <= RX_START;
                        BUSY  <= 1'b1;
                    end
                end

                RX_START: begin
                    if (tick) begin
                        if (rxs) begin
                            // Line went back high before mid-start: a glitch.
                            state <= RX_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end
                end

                RX_DATA: begin
                    if (tick) begin
                        // LSB arrives first, so shifting right leaves bit 0
                        // in position 0 after the last sample.
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end

                RX_STOP: begin
                    if (tick) begin
                        if (rxs) begin
                            // Leaving at mid-stop gives half a bit of margin
                            // for a start edge that follows with no idle gap.
                            DATA  <= shreg;
                            VALID <= 1'b1;
                            state <= RX_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= RX_BREAK;
                        end
                    end
                end

                RX_BREAK: begin
                    // A line held low must not retrigger; wait for idle.
                    if (rxs) begin
                        state <= RX_IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_rx
